// File: rtl/jam_cost_eval.sv
// jam_cost_eval: sums cost-matrix entries over each offered permutation and tracks the minimum total and its multiplicity
module jam_cost_eval #(
    parameter int N  = 8,
    parameter int CW = 7,
    parameter int SW = $clog2(N*(2**CW-1)+1),
    parameter int MW = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       perm_valid,
    input  logic [N-1:0][$clog2(N)-1:0] perm,
    output logic                       perm_req,
    output logic [$clog2(N)-1:0]       W,
    output logic [$clog2(N)-1:0]       J,
    input  logic [CW-1:0]              Cost,
    output logic [SW-1:0]              MinCost,
    output logic [MW-1:0]              MatchCount,
    output logic                       Valid
);
    localparam int IW = $clog2(N);
    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;
    state_t               state_q, state_d;
    logic [N-1:0][IW-1:0] snap_q, snap_d;
    logic [SW-1:0]        sum_q, sum_d, min_q, min_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [MW-1:0]        cnt_q, cnt_d;
    logic                 last_q, last_d, valid_q, valid_d, req_q, req_d, desc;
    always_comb begin
        desc = 1'b1;
        for (int i = 0; i < N; i++) desc = desc & (perm[i] == IW'(N-1-i));
    end
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        last_d  = last_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        min_d   = min_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        req_d   = 1'b0;
        case (state_q)
            IDLE: if (perm_valid) begin
                snap_d  = perm;
                last_d  = desc;
                sum_d   = '0;
                idx_d   = '0;
                req_d   = !desc;
                state_d = ACCUM;
            end
            ACCUM: begin
                sum_d   = sum_q + SW'(Cost);
                idx_d   = idx_q + 1'b1;
                state_d = idx_q == IW'(N-1) ? COMPARE : ACCUM;
            end
            COMPARE: begin
                min_d   = sum_q < min_q ? sum_q : min_q;
                cnt_d   = sum_q < min_q ? MW'(1) : (sum_q == min_q && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
                valid_d = last_q;
                state_d = last_q ? DONE : IDLE;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            last_q  <= 1'b0;
            sum_q   <= '0;
            idx_q   <= '0;
            min_q   <= '1;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            min_q   <= min_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end
    assign W          = state_q == ACCUM ? idx_q : '0;
    assign J          = state_q == ACCUM ? snap_q[idx_q] : '0;
    assign perm_req   = req_q;
    assign MinCost    = min_q;
    assign MatchCount = cnt_q;
    assign Valid      = valid_q;
endmodule
